// File: rtl/uart_tx_fifo_pkg.sv
// uart_pkg: shared types and constants for the UART transmit FIFO.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_fifo_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host write port plus transmitter send/busy handshake.
// The level output exists only when UART_TX_FIFO_LEVEL_EN is defined.
interface uart_tx_fifo_if #(parameter int DEPTH = 16);
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] wr_data;
    logic                   wr_en;
    logic                   full;
    logic                   empty;
    logic                   overflow;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_send;
    logic                   tx_busy;

`ifdef UART_TX_FIFO_LEVEL_EN
    logic [$clog2(DEPTH):0] level;

    modport slave (
        input  wr_data, wr_en, tx_busy,
        output full, empty, overflow, tx_data, tx_send, level
    );

    modport master (
        output wr_data, wr_en, tx_busy,
        input  full, empty, overflow, tx_data, tx_send, level
    );
`else
    modport slave (
        input  wr_data, wr_en, tx_busy,
        output full, empty, overflow, tx_data, tx_send
    );

    modport master (
        output wr_data, wr_en, tx_busy,
        input  full, empty, overflow, tx_data, tx_send
    );
`endif

endinterface

// File: rtl/uart_tx_fifo_mem.sv
// uart_fifo_mem: DEPTH x 8 register array, one synchronous write port and
// one asynchronous read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [UART_DATA_W-1:0] rd_data
);

    logic [UART_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO pacing host bytes into the UART transmitter over send/busy.
// Define UART_TX_FIFO_LEVEL_EN to add the registered occupancy output bus.level.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int BUSY_WAIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int TMR_W  = $clog2(BUSY_WAIT + 1);
    localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_WAIT - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
    end

    tx_fifo_state_t         state, state_next;
    logic [ADDR_W-1:0]      wr_ptr, rd_ptr;
    logic [ADDR_W:0]        count, count_next;
    logic [TMR_W-1:0]       timer;
    logic [UART_DATA_W-1:0] rd_data;
    logic                   push, pop;

    uart_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (bus.wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // A write while full is dropped even if a pop happens the same cycle.
    assign push = bus.wr_en && !bus.full;
    assign pop  = (state == IDLE) && (count != '0) && !bus.tx_busy;

    assign bus.tx_send = (state == SEND);

    always_comb begin
        count_next = (push && !pop) ? count + 1'b1 :
                     (pop && !push) ? count - 1'b1 : count;
        state_next = (state == IDLE)      ? (pop ? SEND : IDLE) :
                     (state == SEND)      ? WAIT_BUSY :
                     (state == WAIT_BUSY) ? (bus.tx_busy ? WAIT_DONE :
                                             (timer == TMR_LAST) ? IDLE : WAIT_BUSY) :
                     (bus.tx_busy ? WAIT_DONE : IDLE);
    end

    // Flags are registered from the next-state count so they track count exactly.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            timer        <= '0;
            bus.tx_data  <= '0;
            bus.full     <= 1'b0;
            bus.empty    <= 1'b1;
            bus.overflow <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            timer        <= (state == WAIT_BUSY) ? timer + 1'b1 : '0;
            bus.full     <= (count_next == FULL_CNT);
            bus.empty    <= (count_next == '0) && (state_next == IDLE);
            bus.overflow <= bus.wr_en && bus.full;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                bus.tx_data <= rd_data;
            end
        end

`ifdef UART_TX_FIFO_LEVEL_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) bus.level <= '0;
        else bus.level <= count_next;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios for uart_tx_fifo with a simple transmitter model.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic hold    = 1'b0;
    logic mbusy   = 1'b0;
    logic no_busy = 1'b0;
    logic [7:0] got [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH(16)) bus ();

    assign bus.tx_busy = hold | mbusy;

    uart_tx_fifo #(.DEPTH(16), .BUSY_WAIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Transmitter model: records every send, then stays busy for 10 cycles unless disabled.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_send) begin
                got.push_back(bus.tx_data);
                if (!no_busy) begin
                    mbusy = 1'b1;
                    repeat (10) @(negedge clk);
                    mbusy = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset;
        reset       = 1'b1;
        hold        = 1'b0;
        no_busy     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        got.delete();
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (2) @(negedge clk);
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", bus.full); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", bus.overflow); end
        total++; if (bus.tx_send !== 1'b0) begin bad++; $display("FAIL reset_tx_send got=%b want=0", bus.tx_send); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", bus.tx_data); end
`ifdef UART_TX_FIFO_LEVEL_EN
        total++; if (bus.level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", bus.level); end
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL idle_empty got=%b want=1", bus.empty); end
    endtask

    task automatic test_single;
        do_reset();
        bus.wr_data = 8'hA5;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        total++; if (bus.tx_send !== 1'b0) begin bad++; $display("FAIL single_send_early got=%b want=0", bus.tx_send); end
        total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL single_empty_after_write got=%b want=0", bus.empty); end
        @(negedge clk);
        total++; if (bus.tx_send !== 1'b1) begin bad++; $display("FAIL single_send_latency got=%b want=1", bus.tx_send); end
        total++; if (bus.tx_data !== 8'hA5) begin bad++; $display("FAIL single_tx_data got=%h want=a5", bus.tx_data); end
        repeat (3) @(negedge clk);
        total++; if (bus.tx_send !== 1'b0) begin bad++; $display("FAIL single_send_width got=%b want=0", bus.tx_send); end
        total++; if (bus.tx_data !== 8'hA5) begin bad++; $display("FAIL single_data_stable got=%h want=a5", bus.tx_data); end
        total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL single_empty_in_flight got=%b want=0", bus.empty); end
        for (int i = 0; i < 40 && !bus.empty; i++) @(negedge clk);
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL single_empty_done got=%b want=1", bus.empty); end
        total++; if (got.size() != 1) begin bad++; $display("FAIL single_send_count got=%0d want=1", got.size()); end
    endtask

    task automatic test_burst;
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wr_data = 8'(i);
            bus.wr_en   = 1'b1;
            @(negedge clk);
            if (i == 14) begin
                total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL burst_full_at_15 got=%b want=0", bus.full); end
            end
        end
        total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL burst_full_at_16 got=%b want=1", bus.full); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL burst_no_overflow got=%b want=0", bus.overflow); end
        bus.wr_data = 8'hEE;
        @(negedge clk);
        bus.wr_en = 1'b0;
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL overflow_pulse got=%b want=1", bus.overflow); end
        @(negedge clk);
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL overflow_one_cycle got=%b want=0", bus.overflow); end
        total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL burst_full_held got=%b want=1", bus.full); end
        hold = 1'b0;
        for (int i = 0; i < 1000 && !(got.size() == 16 && bus.empty); i++) @(negedge clk);
        total++; if (got.size() != 16) begin bad++; $display("FAIL burst_count got=%0d want=16", got.size()); end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            total++; if (got[i] !== 8'(i)) begin bad++; $display("FAIL burst_order idx=%0d got=%h want=%h", i, got[i], 8'(i)); end
        end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL burst_full_drained got=%b want=0", bus.full); end
    endtask

    task automatic test_no_busy;
        int sends [$];
        do_reset();
        no_busy     = 1'b1;
        bus.wr_data = 8'h11;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        bus.wr_data = 8'h22;
        @(negedge clk);
        bus.wr_en = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.tx_send) sends.push_back(c);
            @(negedge clk);
        end
        total++; if (sends.size() != 2) begin bad++; $display("FAIL nobusy_send_count got=%0d want=2", sends.size()); end
        if (sends.size() == 2) begin
            total++; if (sends[1] - sends[0] != 6) begin bad++; $display("FAIL nobusy_gap got=%0d want=6", sends[1] - sends[0]); end
        end
        if (got.size() == 2) begin
            total++; if (got[0] !== 8'h11) begin bad++; $display("FAIL nobusy_first got=%h want=11", got[0]); end
            total++; if (got[1] !== 8'h22) begin bad++; $display("FAIL nobusy_second got=%h want=22", got[1]); end
        end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL nobusy_empty got=%b want=1", bus.empty); end
    endtask

`ifdef UART_TX_FIFO_LEVEL_EN
    task automatic test_level;
        do_reset();
        no_busy = 1'b1;
        hold    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_data = 8'h30 + 8'(i);
            bus.wr_en   = 1'b1;
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        total++; if (bus.level !== 5'd3) begin bad++; $display("FAIL level_three got=%0d want=3", bus.level); end
        hold = 1'b0;
        @(negedge clk);
        total++; if (bus.level !== 5'd2) begin bad++; $display("FAIL level_after_pop got=%0d want=2", bus.level); end
        total++; if (bus.tx_send !== 1'b1) begin bad++; $display("FAIL level_pop_send got=%b want=1", bus.tx_send); end
        repeat (5) @(negedge clk);
        bus.wr_data = 8'h44;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        total++; if (bus.tx_send !== 1'b1) begin bad++; $display("FAIL level_simul_send got=%b want=1", bus.tx_send); end
        total++; if (bus.level !== 5'd2) begin bad++; $display("FAIL level_simul got=%0d want=2", bus.level); end
        repeat (40) @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid;
        bit seen;
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.wr_data = 8'h50 + 8'(i);
            bus.wr_en   = 1'b1;
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        hold      = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.tx_send;
        end
        total++; if (!seen) begin bad++; $display("FAIL midreset_first_send got=0 want=1 within 10 cycles"); end
        repeat (4) @(negedge clk);
        total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL midreset_pre_empty got=%b want=0", bus.empty); end
        reset = 1'b1;
        #1;
        got.delete();
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL midreset_empty got=%b want=1", bus.empty); end
        total++; if (bus.tx_send !== 1'b0) begin bad++; $display("FAIL midreset_tx_send got=%b want=0", bus.tx_send); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL midreset_tx_data got=%h want=00", bus.tx_data); end
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        total++; if (got.size() != 0) begin bad++; $display("FAIL midreset_no_sends got=%0d want=0", got.size()); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL midreset_stays_empty got=%b want=1", bus.empty); end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        test_reset();
        test_single();
        test_burst();
        test_no_busy();
`ifdef UART_TX_FIFO_LEVEL_EN
        test_level();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
